// File: rtl/adc_spi_rx.sv
// adc_spi_rx: SPI ADC frame capture gated by cs_n; define ADC_ZERO_CHECK_EN to reject frames with nonzero leading bits.
module adc_spi_rx #(
  parameter int SCLK_DIV = 4,
  parameter int NBITS = 16,
  parameter int DBITS = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sdata,
  output logic sclk,
  output logic [DBITS-1:0] sample,
  output logic sample_valid,
  output logic busy,
  output logic frame_err
);
  localparam int HW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hp_q, hp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [DBITS-1:0] sample_q, sample_d;
  logic sclk_q, sclk_d, valid_q, valid_d, busy_q, busy_d, err_q, err_d;
  logic cs_prev_q, cs_prev_d, arm_q, arm_d, tc, bad;
`ifdef ADC_ZERO_CHECK_EN
  assign bad = |sh_q[NBITS-1:DBITS];
`else
  assign bad = 1'b0;
`endif
  assign tc = hp_q == HW'(SCLK_DIV - 1);
  always_comb begin
    state_d = state_q;
    hp_d = hp_q;
    bit_d = bit_q;
    sh_d = sh_q;
    sample_d = sample_q;
    sclk_d = sclk_q;
    busy_d = busy_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    cs_prev_d = cs_n;
    // a cs_n already low when reset releases must go high before a frame can start
    arm_d = arm_q | cs_n;
    case (state_q)
      IDLE: if (!cs_n && cs_prev_q && arm_q) begin
        state_d = SHIFT;
        hp_d = '0;
        bit_d = '0;
        sh_d = '0;
        sclk_d = 1'b1;
        busy_d = 1'b1;
      end
      SHIFT: begin
        hp_d = tc ? '0 : hp_q + 1'b1;
        sclk_d = tc ? ~sclk_q : sclk_q;
        if (tc && !sclk_q) begin
          sh_d = {sh_q[NBITS-2:0], sdata};
          bit_d = bit_q + 1'b1;
        end
        // the final rising edge wins over a simultaneous cs_n release
        if (bit_d == BW'(NBITS)) state_d = DONE;
        else if (cs_n) begin
          state_d = IDLE;
          sclk_d = 1'b1;
          busy_d = 1'b0;
          err_d = 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        sample_d = bad ? sample_q : sh_q[DBITS-1:0];
        valid_d = !bad;
        err_d = bad;
        state_d = cs_n ? IDLE : WAIT_HIGH;
      end
      default: state_d = cs_n ? IDLE : WAIT_HIGH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      sample_q <= '0;
      sclk_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      cs_prev_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q <= hp_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      sample_q <= sample_d;
      sclk_q <= sclk_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      err_q <= err_d;
      cs_prev_q <= cs_prev_d;
      arm_q <= arm_d;
    end
  end
  assign sclk = sclk_q;
  assign sample = sample_q;
  assign sample_valid = valid_q;
  assign busy = busy_q;
  assign frame_err = err_q;
endmodule

// File: doc/adc_spi_rx.md
# adc_spi_rx

Serial capture stage fed directly by the chip-select pulse generator. The generator drives `cs_n` low for a fixed window each period. During that window this block generates the ADC serial clock, shifts in one 16-bit frame (4 leading zeros plus 12 data bits, MSB first), and presents the 12-bit sample with a one-cycle valid strobe to the servo control logic downstream.

## Interface
- `SCLK_DIV`, 4: clk cycles per sclk half-period; must be ≥ 1.
- `NBITS`, 16: sclk rising edges per frame.
- `DBITS`, 12: data bits, taken from the last `DBITS` bits shifted in.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `cs_n`  in  1  chip select from the generator; registered in the clk domain, so no synchronizer.
- `sdata`  in  1  ADC serial data.
- `sclk`  out  1  ADC serial clock; idles high.
- `sample`  out  DBITS  last good sample; held between frames.
- `sample_valid`  out  1  one-cycle strobe when `sample` updates.
- `busy`  out  1  high while a frame is being shifted.
- `frame_err`  out  1  one-cycle strobe when a frame aborts or is rejected.

## Operation
- States:
  - IDLE: sclk=1, waiting for `cs_n` falling edge. Previous `cs_n` is kept in an internal flop.
  - SHIFT: generating sclk and shifting.
  - DONE: publishing the sample.
  - WAIT_HIGH: frame finished, waiting for `cs_n` to return high.
- IDLE→SHIFT: on the edge where `cs_n`=0 and the previous `cs_n`=1. Clears the half-period counter, bit counter and shift register; sets `busy`.
- SHIFT: the half-period counter counts 0..SCLK_DIV-1. At terminal count, sclk toggles and the counter wraps to 0.
  - 1→0 toggle: the ADC launches a bit.
  - 0→1 toggle: on that same clk edge, `sdata` is shifted into the LSB and the bit counter increments.
- SHIFT→DONE: when the bit counter reaches `NBITS`.
- DONE: lasts one cycle. `sample` ← shift[DBITS-1:0]; `sample_valid`=1; `busy`=0. Next state is WAIT_HIGH if `cs_n`=0, otherwise IDLE.
- WAIT_HIGH→IDLE: when `cs_n`=1. Exactly one frame is captured per low window, even if `cs_n` stays low.
- Abort: `cs_n`=1 while in SHIFT → IDLE on the next edge, with sclk=1, `busy`=0, `frame_err` pulsed for one cycle. `sample` is unchanged and no `sample_valid` is issued.
- Widths:
  - Half-period counter: $clog2(SCLK_DIV+1) bits.
  - Bit counter: $clog2(NBITS+1) bits.
  - Shift register: `NBITS` bits.
  - No counter exceeds its terminal value.

## Timing
- Reset values: sclk=1, sample=0, sample_valid=0, busy=0, frame_err=0; state=IDLE; previous-`cs_n` flop=1.
- Reset mid-frame returns to IDLE immediately, with no strobe. A `cs_n` already low at reset release does not start a frame until it goes high and then low again.
- Edge E0: falling edge of `cs_n` detected. `busy`=1 from E0.
- sclk falls at E0+SCLK_DIV.
- Rising edge k (k=1..NBITS) occurs at E0+2·k·SCLK_DIV; `sdata` is sampled at that edge.
- DONE is entered at E0+2·NBITS·SCLK_DIV (E0+128 with defaults). `sample_valid` and `sample` update one edge later (E0+129).
- Required low window ≥ 2·NBITS·SCLK_DIV+1 cycles. With defaults the frame needs 129 cycles, inside the generator's 138-cycle low window.
- `cs_n` rising at exactly the DONE edge completes normally: valid issued, then IDLE.

## Configuration
- `ADC_ZERO_CHECK_EN` defined:
  - In DONE, if any of the leading `NBITS-DBITS` shifted bits is 1, the frame is rejected.
  - On rejection, `frame_err` pulses instead of `sample_valid` and `sample` is unchanged.
- `ADC_ZERO_CHECK_EN` undefined: leading bits are ignored, and `frame_err` is asserted only on abort.

## Test plan
- Normal frame: `cs_n` high 500 cycles then low 138; `sdata` stream 0000_1010_0101_1100 → `sample`=12'hA5C, `sample_valid` high exactly at E0+129 for 1 cycle, 16 sclk rising edges at 8-cycle spacing.
- Repeated generator periods (500 high/138 low, 3 periods) with distinct patterns → 3 valid strobes, each with correct value, and sclk idle high between windows.
- `cs_n` held low for 400 cycles → exactly one `sample_valid`, and sclk stays high after E0+128.
- `cs_n` rises at E0+60 → `frame_err` pulse, no `sample_valid`, `sample` keeps its prior value (e.g. 12'hA5C), `busy` drops.
- `rst` asserted at E0+70 → all outputs at reset values immediately. A new frame starts only after a fresh `cs_n` falling edge.
- With `ADC_ZERO_CHECK_EN`, stream 0100_1111_1111_1111 → `frame_err` pulse and `sample` unchanged. Without it → `sample`=12'hFFF and a valid strobe.
